// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC INTA sequencer slice.
package pic_pkg;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned BASE_W  = 5;
  localparam int unsigned VEC_W   = BASE_W + LVL_W;

  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } pic_state_e;

  function automatic logic [VEC_W-1:0] make_vector(input logic [BASE_W-1:0] base,
                                                   input logic [LVL_W-1:0]  lvl);
    return {base, lvl};
  endfunction

endpackage

// File: rtl/pic_isr_prio_enc.sv
// Lowest-set-bit encoder over the ISR; index 0 is the highest priority level.
module pic_isr_prio_enc
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] vec,
  output logic               valid_c,
  output logic [LVL_W-1:0]   idx_c
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid_c = 1'b1;
        idx_c   = LVL_W'(i);
      end
    end
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU-facing PIC end: INT raise, two-pulse INTA handshake, ISR ownership and EOI.
// Optional auto-EOI support is enabled by defining PIC_AEOI_EN.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hp_valid,
  input  logic [LVL_W-1:0]    highest_priority_int,
  input  logic [BASE_W-1:0]   icw2_base,
  input  logic                inta_n,
  input  logic                eoi,
  input  logic                eoi_specific,
  input  logic [LVL_W-1:0]    eoi_level,
  input  logic                aeoi,
  output logic                int_out,
  output logic [NUM_IRQ-1:0]  isr,
  output logic [NUM_IRQ-1:0]  irr_clear,
  output logic [VEC_W-1:0]    data_out,
  output logic                data_oe,
  output logic [LVL_W-1:0]    last_serviced
);

  pic_state_e state_q, state_d;

  logic                inta_q;
  logic                fall_c, rise_c;
  logic                isr_valid_c;
  logic [LVL_W-1:0]    isr_low_c;
  logic                req_ok_c;
  logic                aeoi_en_c;

  logic                int_out_d;
  logic [NUM_IRQ-1:0]  isr_d, set_mask_c, clr_mask_c, irr_clear_d;
  logic [VEC_W-1:0]    data_out_d;
  logic                data_oe_d;
  logic [LVL_W-1:0]    last_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic                spur_q, spur_d;

`ifdef PIC_AEOI_EN
  assign aeoi_en_c = aeoi;
`else
  logic aeoi_unused_c;
  assign aeoi_unused_c = aeoi;
  assign aeoi_en_c     = 1'b0;
`endif

  pic_isr_prio_enc u_isr_enc (
    .vec     (isr),
    .valid_c (isr_valid_c),
    .idx_c   (isr_low_c)
  );

  assign fall_c   = inta_q & ~inta_n;
  assign rise_c   = ~inta_q & inta_n;
  // Fixed nesting: only a strictly higher priority (lower index) may interrupt.
  assign req_ok_c = hp_valid && (!isr_valid_c || (highest_priority_int < isr_low_c));

  always_comb begin
    state_d     = state_q;
    int_out_d   = int_out;
    irr_clear_d = '0;
    data_out_d  = data_out;
    data_oe_d   = data_oe;
    last_d      = last_serviced;
    lvl_d       = lvl_q;
    spur_d      = spur_q;
    set_mask_c  = '0;
    clr_mask_c  = '0;

    unique case (state_q)
      IDLE: begin
        if (fall_c) begin
          // Unsolicited acknowledge: answer with the spurious vector.
          state_d   = ACK1;
          lvl_d     = SPURIOUS_LVL;
          spur_d    = 1'b1;
          int_out_d = 1'b0;
        end else if (req_ok_c) begin
          state_d   = PEND;
          int_out_d = 1'b1;
        end
      end
      PEND: begin
        int_out_d = 1'b1;
        if (fall_c) begin
          state_d   = ACK1;
          int_out_d = 1'b0;
          if (hp_valid) begin
            lvl_d       = highest_priority_int;
            spur_d      = 1'b0;
            set_mask_c  = NUM_IRQ'(1) << highest_priority_int;
            irr_clear_d = NUM_IRQ'(1) << highest_priority_int;
          end else begin
            lvl_d  = SPURIOUS_LVL;
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (rise_c) state_d = GAP;
      end
      GAP: begin
        if (fall_c) begin
          state_d    = ACK2;
          data_out_d = make_vector(icw2_base, lvl_q);
          data_oe_d  = 1'b1;
        end
      end
      ACK2: begin
        if (rise_c) begin
          state_d    = IDLE;
          data_oe_d  = 1'b0;
          data_out_d = '0;
          if (aeoi_en_c && !spur_q) begin
            clr_mask_c = NUM_IRQ'(1) << lvl_q;
            last_d     = lvl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI is accepted in every state.
    if (eoi) begin
      if (eoi_specific) begin
        if (isr[eoi_level]) begin
          clr_mask_c = clr_mask_c | (NUM_IRQ'(1) << eoi_level);
          last_d     = eoi_level;
        end
      end else if (isr_valid_c) begin
        clr_mask_c = clr_mask_c | (NUM_IRQ'(1) << isr_low_c);
        last_d     = isr_low_c;
      end
    end

    // Set wins over a simultaneous clear of the same bit.
    isr_d = (isr & ~clr_mask_c) | set_mask_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      inta_q        <= inta_n;
      int_out       <= 1'b0;
      isr           <= '0;
      irr_clear     <= '0;
      data_out      <= '0;
      data_oe       <= 1'b0;
      last_serviced <= SPURIOUS_LVL;
      lvl_q         <= SPURIOUS_LVL;
      spur_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      inta_q        <= inta_n;
      int_out       <= int_out_d;
      isr           <= isr_d;
      irr_clear     <= irr_clear_d;
      data_out      <= data_out_d;
      data_oe       <= data_oe_d;
      last_serviced <= last_d;
      lvl_q         <= lvl_d;
      spur_q        <= spur_d;
    end
  end

endmodule
